siso_frame_ctrl: RTL and testbench

//  Sequencer for the siso_left serial shift register.

---
 rtl/siso_pkg.sv | 9 +
 rtl/siso_bit_cnt.sv | 22 ++
 rtl/siso_frame_ctrl.sv | 86 ++++++++
 tb/tb_siso_frame_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// rtl/siso_pkg.sv - shared types and default sizes for the siso frame controller
package siso_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} siso_state_e;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_SR_DEPTH = 4;

endpackage

// File: rtl/siso_bit_cnt.sv
// rtl/siso_bit_cnt.sv - clear/enable up-counter with terminal-count compare
module siso_bit_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  always_ff @(posedge clk) begin
    if (!rst)       cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/siso_frame_ctrl.sv
// rtl/siso_frame_ctrl.sv - serializes a word through siso_left, flushes it, and rebuilds the returned word
module siso_frame_ctrl
  import siso_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SR_DEPTH = DEF_SR_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  input  logic              sr_hold,
  output logic              sr_enb,
  output logic              sr_inp,
  input  logic              sr_out,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + SR_DEPTH);
  localparam logic [CW-1:0] TERM_SHIFT = CW'(DATA_W - 1);
  localparam logic [CW-1:0] TERM_FLUSH = CW'(DATA_W + SR_DEPTH - 1);
  localparam logic [CW-1:0] CAP_START  = CW'(SR_DEPTH);

  siso_state_e       state;
  logic [DATA_W-1:0] tx, orig, rx;
  logic [CW-1:0]     cnt, term;
  logic              at_term, step, accept, cnt_en, capture;

  assign step    = (state == SHIFT || state == FLUSH) && !sr_hold;
  assign accept  = in_vld && in_rdy;
  assign capture = step && (cnt >= CAP_START);
  assign term    = (state == SHIFT) ? TERM_SHIFT : TERM_FLUSH;
  // Stop counting on the last flush step so the counter never wraps.
  assign cnt_en  = step && !(state == FLUSH && at_term);

  siso_bit_cnt #(.W(CW)) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .en      (cnt_en),
    .term    (term),
    .cnt     (cnt),
    .at_term (at_term)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      tx    <= '0;
      orig  <= '0;
      rx    <= '0;
    end else begin
      if (capture) rx <= {rx[DATA_W-2:0], sr_out};
      case (state)
        IDLE: if (in_vld) begin
          tx    <= in_data;
          orig  <= in_data;
          rx    <= '0;
          state <= SHIFT;
        end
        SHIFT: if (step) begin
          tx <= tx << 1;
          if (at_term) state <= FLUSH;
        end
        FLUSH: if (step && at_term) state <= DONE;
        DONE:  if (out_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Every visible output is forced low while reset is asserted.
  assign in_rdy   = rst && (state == IDLE);
  assign sr_enb   = rst && step;
  assign sr_inp   = rst && (state == SHIFT) && tx[DATA_W-1];
  assign out_vld  = rst && (state == DONE);
  assign out_data = rst ? rx : '0;
  assign out_err  = out_vld && (rx != orig);
  assign busy     = rst && (state != IDLE);

endmodule

// File: tb/tb_siso_frame_ctrl.sv
// tb/tb_siso_frame_ctrl.sv - randomized loopback bench for siso_frame_ctrl
module tb_siso_frame_ctrl;

  localparam int DATA_W   = 8;
  localparam int SR_DEPTH = 4;
  localparam int NEN      = DATA_W + SR_DEPTH;

  logic              clk = 1'b0, rst = 1'b0;
  logic              in_vld = 1'b0, sr_hold = 1'b0, out_rdy = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_rdy, sr_enb, sr_inp, sr_out, out_vld, out_err, busy;
  logic [DATA_W-1:0] out_data;

  logic [SR_DEPTH-1:0] lb_sr = '0;
  logic                stuck = 1'b0;
  int                  total = 0, bad = 0;
  int                  cyc = 0, last_acc = 0;
  bit                  prev_keep = 1'b0;

  siso_frame_ctrl #(.DATA_W(DATA_W), .SR_DEPTH(SR_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .sr_hold(sr_hold), .sr_enb(sr_enb), .sr_inp(sr_inp), .sr_out(sr_out),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_err(out_err), .busy(busy)
  );

  // siso_left in loopback; stuck forces its output to 0
  always @(posedge clk) if (sr_enb) lb_sr <= {lb_sr[SR_DEPTH-2:0], sr_inp};
  assign sr_out = stuck ? 1'b0 : lb_sr[SR_DEPTH-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input logic [DATA_W-1:0] d, input logic [63:0] hold_vec,
                           input int rdy_delay, input int abort_after, input bit keep_vld);
    int   en_cnt = 0, holds = 0, done_cycles = 0;
    logic [DATA_W-1:0] exp_data;
    logic exp_inp;
    exp_data = stuck ? '0 : d;
    @(posedge clk); #1;
    in_vld = 1'b1; in_data = d; sr_hold = hold_vec[0]; out_rdy = 1'b0;
    @(negedge clk);
    check("in_rdy_idle", in_rdy, 1);
    check("busy_idle", busy, 0);
    if (!in_rdy) begin
      in_vld = 1'b0;
      return;
    end
    if (keep_vld && prev_keep) check("throughput", cyc - last_acc, NEN + 2);
    last_acc  = cyc;
    prev_keep = keep_vld;
    for (int k = 1; k < 200; k++) begin
      @(posedge clk); #1;
      if (!keep_vld) in_vld = 1'b0;
      if (abort_after > 0 && en_cnt == abort_after) begin
        rst = 1'b0; sr_hold = 1'b0;
        @(negedge clk);
        check("rst_out_vld", out_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_sr_enb", sr_enb, 0);
        @(posedge clk); #1;
        rst = 1'b1; in_vld = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_in_rdy", in_rdy, 1);
        check("abort_out_vld", out_vld, 0);
        return;
      end
      if (en_cnt < NEN) begin
        sr_hold = hold_vec[k % 64];
        @(negedge clk);
        check("sr_enb", sr_enb, !sr_hold);
        check("out_vld_early", out_vld, 0);
        check("busy_frame", busy, 1);
        if (!sr_hold) begin
          exp_inp = 1'b0;
          if (en_cnt < DATA_W) exp_inp = d[DATA_W-1-en_cnt];
          check("sr_inp", sr_inp, exp_inp);
          en_cnt++;
        end else begin
          holds++;
        end
      end else begin
        sr_hold = 1'($urandom_range(0, 1));
        out_rdy = (done_cycles >= rdy_delay);
        @(negedge clk);
        if (done_cycles == 0) check("latency", k, NEN + 1 + holds);
        check("out_vld", out_vld, 1);
        check("out_data", out_data, exp_data);
        check("out_err", out_err, exp_data != d);
        check("in_rdy_done", in_rdy, 0);
        check("sr_enb_done", sr_enb, 0);
        if (out_rdy) return;
        done_cycles++;
      end
    end
    check("frame_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_rdy", in_rdy, 0);
    check("reset_out_vld", out_vld, 0);
    check("reset_busy", busy, 0);
    check("reset_sr_enb", sr_enb, 0);
    check("reset_sr_inp", sr_inp, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_err", out_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("release_in_rdy", in_rdy, 1);

    run_frame(8'hA5, 64'h0, 0, 0, 1'b0);
    run_frame(8'h3C, 64'h3038, 0, 0, 1'b0);
    run_frame(8'hFF, 64'h0, 5, 0, 1'b0);
    stuck = 1'b1;
    run_frame(8'h81, 64'h0, 0, 0, 1'b0);
    stuck = 1'b0;
    run_frame(8'h5A, 64'h0, 0, 6, 1'b0);
    run_frame(8'h99, 64'h0, 0, 0, 1'b0);

    prev_keep = 1'b0;
    run_frame(8'h01, 64'h0, 0, 0, 1'b1);
    run_frame(8'h80, 64'h0, 0, 0, 1'b1);
    run_frame(8'h00, 64'h0, 0, 0, 1'b1);
    in_vld    = 1'b0;
    prev_keep = 1'b0;

    for (int n = 0; n < 20; n++) begin
      logic [63:0] hv;
      hv = {$urandom, $urandom} & {$urandom, $urandom};
      stuck = (n % 7 == 3);
      run_frame(DATA_W'($urandom), hv, $urandom_range(0, 3), 0, 1'b0);
    end
    stuck = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
